lsu: RTL and testbench

- Load/store unit: the memory stage directly downstream of the control unit.
- Consumes mem_read/mem_write decoded by control, the ALU-computed address and rs2 store data.
- Runs a request/grant/response transaction on the data-memory bus and stalls the pipeline until it completes.
- Returns load data for the WB_MEM writeback select.

---
 rtl/lsu.sv | 155 +++++++++++++++
 tb/tb_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one request/grant/response data-memory access per instruction.
// Optional bus timeout abort is enabled by defining LSU_TIMEOUT_EN.
module lsu #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e              state_q, state_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic                err_q, err_d;
  logic                access;

  assign access = valid_i & (mem_read_i | mem_write_i);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d       = state_q;
    dmem_req_d    = dmem_req_q;
    dmem_we_d     = dmem_we_q;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    stall_o       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          if (addr_i[0]) begin
            state_d = DONE;
            err_d   = 1'b1;
            if (mem_read_i) rdata_d = '0;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_addr_d  = addr_i;
            dmem_wdata_d = wdata_i;
            dmem_we_d    = ~mem_read_i;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dmem_gnt_i) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d       = DONE;
            rdata_valid_d = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          state_d       = DONE;
          rdata_d       = dmem_rdata_i;
          rdata_valid_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    // Abort only when the cycle made no progress; a grant or rvalid on the
    // final counted cycle still completes normally.
    cnt_d = cnt_q;
    if (state_q == REQ || state_q == RESP) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout && state_d == state_q) begin
        state_d       = DONE;
        dmem_req_d    = 1'b0;
        err_d         = 1'b1;
        rdata_valid_d = 1'b0;
        if (!dmem_we_q) rdata_d = '0;
      end
    end
    if (state_q == IDLE && state_d == REQ) cnt_d = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dmem_req_q    <= dmem_req_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign dmem_addr_o   = dmem_addr_q;
  assign dmem_wdata_o  = dmem_wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset/timeout sequences, and random
// accesses against a word-memory model of the data bus.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [15:0] addr_i, wdata_i;
  logic        stall_o, rdata_valid_o, err_o;
  logic [15:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [15:0] dmem_rdata_i;

  always #5 clk = ~clk;

  lsu #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .err_o(err_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [256];
  logic [15:0] rdata_model;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    int          g;
    int          r;
    logic [15:0] bus;
    logic [15:0] exp_rd;
    bit          exp_err;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; the DONE cycle is cycle lat-1 counted from the request cycle.
  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input int g, input int r,
                         input logic [15:0] bus_d, input logic [15:0] exp_rd,
                         input bit exp_err, input int lat);
    bit mis = a[0];
    int done_k = lat - 1;
    bit in_req;
    for (int k = 0; k <= done_k; k++) begin
      if (k == 0) begin
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; addr_i = a; wdata_i = wd;
      end
      if (k == done_k) begin
        // A fresh access offered in DONE must be ignored
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        addr_i = 16'h0080; wdata_i = 16'h0;
      end
      dmem_gnt_i    = !mis && (k == g + 1);
      dmem_rvalid_i = !mis && rd && (k == g + 1 + r);
      dmem_rdata_i  = dmem_rvalid_i ? bus_d : 16'hDEAD;
      #1;
      in_req = !mis && k >= 1 && k <= g + 1;
      chk("stall", stall_o, k != done_k);
      chk("req", dmem_req_o, in_req);
      if (in_req) begin
        chk("we", dmem_we_o, !rd);
        chk("addr", dmem_addr_o, a);
        if (!rd) chk("wdata", dmem_wdata_o, wd);
      end
      chk("rdata_valid", rdata_valid_o, (k == done_k) && !exp_err);
      chk("err", err_o, (k == done_k) && exp_err);
      if (k == done_k) chk("rdata", rdata_o, exp_rd);
      step();
    end
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    addr_i = '0; wdata_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 1'b0, 3};
    tbl[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 3, 2, 16'h1234, 16'h1234, 1'b0, 8};
    tbl[2] = '{1'b1, 1'b0, 16'h0011, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[3] = '{1'b1, 1'b1, 16'h0020, 16'h9999, 0, 1, 16'h5A5A, 16'h5A5A, 1'b0, 4};
    tbl[4] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 1, 1, 16'h0C3C, 16'h0C3C, 1'b0, 5};
    tbl[5] = '{1'b0, 1'b1, 16'h0031, 16'h1111, 0, 0, 16'h0000, 16'h0C3C, 1'b1, 2};
    tbl[6] = '{1'b0, 1'b1, 16'h00FE, 16'h7777, 2, 0, 16'h0000, 16'h0C3C, 1'b0, 5};

    #12;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 16'h0);
    chk("rst_wdata", dmem_wdata_o, 16'h0);
    chk("rst_rdata", rdata_o, 16'h0);
    chk("rst_rvalid", rdata_valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].g, tbl[i].r,
              tbl[i].bus, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].lat);

    // Reset while waiting for a load response
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 16'h0040;
    #1; chk("rr_stall_idle", stall_o, 1'b1);
    step();
    dmem_gnt_i = 1'b1;
    #1; chk("rr_req", dmem_req_o, 1'b1);
    step();
    dmem_gnt_i = 1'b0;
    #1; chk("rr_stall_resp", stall_o, 1'b1);
    valid_i = 1'b0; mem_read_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rr_stall", stall_o, 1'b0);
    chk("rr_req0", dmem_req_o, 1'b0);
    chk("rr_addr", dmem_addr_o, 16'h0);
    chk("rr_rdata", rdata_o, 16'h0);
    chk("rr_rvalid", rdata_valid_o, 1'b0);
    chk("rr_err", err_o, 1'b0);
    rst_n = 1'b1;
    step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 16'hFFFF;
    #1; chk("rr_late_stall", stall_o, 1'b0);
    step();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rr_late_rdata", rdata_o, 16'h0);
    chk("rr_late_rvalid", rdata_valid_o, 1'b0);
    chk("rr_late_req", dmem_req_o, 1'b0);
    rdata_model = 16'h0;
    step();

    // Random accesses against the memory model
    for (int n = 0; n < 60; n++) begin
      int op = int'($urandom_range(0, 3));
      logic [15:0] a = {8'h00, 8'($urandom)};
      logic [15:0] wd = 16'($urandom);
      int g = int'($urandom_range(0, 2));
      int r = int'($urandom_range(1, 3));
      bit rd, wr, mis;
      logic [15:0] bus_d;
      int lat;
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (op == 0) begin
        valid_i = 1'($urandom); mem_read_i = 1'b0; mem_write_i = 1'b0; addr_i = a;
        #1;
        chk("idle_stall", stall_o, 1'b0);
        chk("idle_req", dmem_req_o, 1'b0);
        step();
        valid_i = 1'b0;
        continue;
      end
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 3);
      mis = a[0];
      bus_d = mem[a[7:0]];
      if (mis) begin
        lat = 2;
        if (rd) rdata_model = 16'h0;
      end else if (rd) begin
        lat = g + r + 3;
        rdata_model = mem[a[7:0]];
      end else begin
        lat = g + 3;
        mem[a[7:0]] = wd;
      end
      run_txn(rd, wr, a, wd, g, r, bus_d, rdata_model, mis, lat);
    end

`ifdef LSU_TIMEOUT_EN
    // Load whose grant never arrives
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; addr_i = 16'h0042;
    for (int k = 0; k <= 9; k++) begin
      #1;
      chk("to_req", dmem_req_o, (k >= 1 && k <= 8));
      chk("to_stall", stall_o, k != 9);
      chk("to_err", err_o, k == 9);
      if (k == 9) chk("to_rdata", rdata_o, 16'h0);
      step();
      if (k == 0) valid_i = 1'b1;
    end
    valid_i = 1'b0; mem_read_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
